// File: rtl/msa_stream_extender.sv
// SHA-2 message-schedule generator: takes one 16-word block and streams W[0..ROUNDS-1],
// LANES words per beat, from a rolling 16-word window.
module msa_stream_extender #(
    parameter int WORD_W = 32,
    parameter int LANES  = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      blk_vld,
    output logic                      blk_rdy,
    input  logic [16*WORD_W-1:0]      blk_data,
    output logic                      w_vld,
    input  logic                      w_rdy,
    output logic [LANES*WORD_W-1:0]   w_data,
    output logic [6:0]                w_idx,
    output logic                      w_last
);

    localparam int ROUNDS = (WORD_W == 64) ? 80 : 64;
    localparam logic [6:0] LAST_IDX = 7'(ROUNDS - LANES);
    localparam logic [6:0] LANE_STEP = 7'(LANES);

    localparam int S0_R1 = (WORD_W == 64) ? 1  : 7;
    localparam int S0_R2 = (WORD_W == 64) ? 8  : 18;
    localparam int S0_SH = (WORD_W == 64) ? 7  : 3;
    localparam int S1_R1 = (WORD_W == 64) ? 19 : 17;
    localparam int S1_R2 = (WORD_W == 64) ? 61 : 19;
    localparam int S1_SH = (WORD_W == 64) ? 6  : 10;

    if (WORD_W != 32 && WORD_W != 64) begin : g_bad_word_w
        $error("msa_stream_extender: WORD_W must be 32 or 64");
    end
    if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8) begin : g_bad_lanes
        $error("msa_stream_extender: LANES must be 1, 2, 4 or 8");
    end

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t            state, state_nxt;
    logic [6:0]        idx, idx_nxt;
    logic              load, adv;
    logic [WORD_W-1:0] window  [16];
    logic [WORD_W-1:0] win_nxt [16];

    function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int n);
        return (x >> n) | (x << (WORD_W - n));
    endfunction

    function automatic logic [WORD_W-1:0] sig0(input logic [WORD_W-1:0] x);
        return rotr(x, S0_R1) ^ rotr(x, S0_R2) ^ (x >> S0_SH);
    endfunction

    function automatic logic [WORD_W-1:0] sig1(input logic [WORD_W-1:0] x);
        return rotr(x, S1_R1) ^ rotr(x, S1_R2) ^ (x >> S1_SH);
    endfunction

    // Lanes chain: each new word may depend on words produced earlier in the same beat.
    always_comb begin : extend
        logic [WORD_W-1:0] ext [16+LANES];
        for (int i = 0; i < 16; i++) begin
            ext[i] = window[i];
        end
        for (int k = 0; k < LANES; k++) begin
            ext[16+k] = sig1(ext[14+k]) + ext[9+k] + sig0(ext[1+k]) + ext[k];
        end
        for (int i = 0; i < 16; i++) begin
            win_nxt[i] = ext[LANES+i];
        end
    end

    // NOTE: every signal gets a default first so no path through the case infers a latch.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        load      = 1'b0;
        adv       = 1'b0;
        if (flush) begin
            state_nxt = IDLE;
            idx_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (blk_vld) begin
                        load      = 1'b1;
                        state_nxt = RUN;
                        idx_nxt   = '0;
                    end
                end
                RUN: begin
                    if (w_rdy) begin
                        if (idx == LAST_IDX) begin
                            state_nxt = IDLE;
                            idx_nxt   = '0;
                        end else begin
                            adv     = 1'b1;
                            idx_nxt = idx + LANE_STEP;
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    // NOTE: the window is pure datapath and is not reset; it is always loaded before it is shown.
    always_ff @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < 16; i++) begin
                window[i] <= blk_data[i*WORD_W +: WORD_W];
            end
        end else if (adv) begin
            window <= win_nxt;
        end
    end

    assign blk_rdy = (state == IDLE);
    assign w_vld   = (state == RUN);
    assign w_idx   = idx;
    assign w_last  = (state == RUN) && (idx == LAST_IDX);

    for (genvar j = 0; j < LANES; j++) begin : g_lane
        assign w_data[j*WORD_W +: WORD_W] = window[j];
    end

endmodule

// File: tb/tb_msa_stream_extender.sv
// Bench for msa_stream_extender: SHA-256 single-lane instance and SHA-512 four-lane instance,
// checked against an independent full-array schedule model.
module tb_msa_stream_extender;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic         flush32, blk_vld32, blk_rdy32, w_vld32, w_rdy32, w_last32;
    logic [511:0] blk_data32;
    logic [31:0]  w_data32;
    logic [6:0]   w_idx32;

    logic          flush64, blk_vld64, blk_rdy64, w_vld64, w_rdy64, w_last64;
    logic [1023:0] blk_data64;
    logic [255:0]  w_data64;
    logic [6:0]    w_idx64;

    msa_stream_extender #(.WORD_W(32), .LANES(1)) dut32 (
        .clk(clk), .rst(rst), .flush(flush32), .blk_vld(blk_vld32), .blk_rdy(blk_rdy32),
        .blk_data(blk_data32), .w_vld(w_vld32), .w_rdy(w_rdy32), .w_data(w_data32),
        .w_idx(w_idx32), .w_last(w_last32)
    );

    msa_stream_extender #(.WORD_W(64), .LANES(4)) dut64 (
        .clk(clk), .rst(rst), .flush(flush64), .blk_vld(blk_vld64), .blk_rdy(blk_rdy64),
        .blk_data(blk_data64), .w_vld(w_vld64), .w_rdy(w_rdy64), .w_data(w_data64),
        .w_idx(w_idx64), .w_last(w_last64)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [63:0] mblk [16];
    logic [63:0] mw   [80];

    function automatic logic [31:0] r32(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction
    function automatic logic [63:0] r64(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction
    function automatic logic [31:0] s0_32(input logic [31:0] x);
        return r32(x, 7) ^ r32(x, 18) ^ (x >> 3);
    endfunction
    function automatic logic [31:0] s1_32(input logic [31:0] x);
        return r32(x, 17) ^ r32(x, 19) ^ (x >> 10);
    endfunction
    function automatic logic [63:0] s0_64(input logic [63:0] x);
        return r64(x, 1) ^ r64(x, 8) ^ (x >> 7);
    endfunction
    function automatic logic [63:0] s1_64(input logic [63:0] x);
        return r64(x, 19) ^ r64(x, 61) ^ (x >> 6);
    endfunction

    task automatic build_model(input bit is512);
        logic [31:0] v;
        for (int t = 0; t < 16; t++) begin
            mw[t] = is512 ? mblk[t] : {32'h0, mblk[t][31:0]};
        end
        for (int t = 16; t < 80; t++) begin
            if (is512) begin
                mw[t] = s1_64(mw[t-2]) + mw[t-7] + s0_64(mw[t-15]) + mw[t-16];
            end else begin
                v = s1_32(mw[t-2][31:0]) + mw[t-7][31:0] + s0_32(mw[t-15][31:0]) + mw[t-16][31:0];
                mw[t] = {32'h0, v};
            end
        end
    endtask

    // ---------------- scoreboard for the 4-lane SHA-512 instance ----------------
    typedef struct {
        logic [6:0]   idx;
        logic [255:0] data;
        logic         last;
    } beat_t;

    beat_t sbq [$];

    task automatic push_block64();
        beat_t b;
        for (int k = 0; k < 20; k++) begin
            b.idx  = 7'(k * 4);
            b.data = {mw[4*k+3], mw[4*k+2], mw[4*k+1], mw[4*k]};
            b.last = (k == 19);
            sbq.push_back(b);
        end
    endtask

    logic         stalled = 1'b0;
    logic [255:0] hold_data;
    logic [6:0]   hold_idx;

    always @(negedge clk) begin : monitor
        beat_t b;
        if (w_vld64 === 1'b1 && stalled) begin
            check("stall_data", w_data64, hold_data);
            check("stall_idx", 256'(w_idx64), 256'(hold_idx));
        end
        stalled   = (w_vld64 === 1'b1) && !w_rdy64 && !rst && !flush64;
        hold_data = w_data64;
        hold_idx  = w_idx64;
        if (w_vld64 === 1'b1 && w_rdy64 && !rst && !flush64) begin
            if (sbq.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_beat: got beat at idx %0d, expected no beat", w_idx64);
            end else begin
                b = sbq.pop_front();
                check($sformatf("w64_idx@%0d", b.idx), 256'(w_idx64), 256'(b.idx));
                check($sformatf("w64_data@%0d", b.idx), w_data64, b.data);
                check($sformatf("w64_last@%0d", b.idx), 256'(w_last64), 256'(b.last));
            end
        end
    end

    // Loads a random block into the model and offers it; returns after the accepting edge.
    task automatic send_block64(input int unsigned seed, input bit keep_vld);
        int c;
        void'($urandom(seed));
        for (int i = 0; i < 16; i++) begin
            mblk[i] = {$urandom(), $urandom()};
        end
        build_model(1'b1);
        for (int i = 0; i < 16; i++) begin
            blk_data64[i*64 +: 64] = mblk[i];
        end
        push_block64();
        blk_vld64 = 1'b1;
        c = 0;
        while (!blk_rdy64 && c < 200) begin
            @(posedge clk); #1;
            c++;
        end
        check("blk_accept_timeout", 256'(blk_rdy64), 256'(1));
        @(posedge clk); #1;
        blk_vld64 = keep_vld;
    endtask

    task automatic run_until_empty(input bit rnd, input int budget);
        for (int c = 0; c < budget; c++) begin
            w_rdy64 = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge clk); #1;
            if (sbq.size() == 0) break;
        end
        check("drain_timeout", 256'(sbq.size()), 256'(0));
        sbq.delete();
        w_rdy64 = 1'b1;
    endtask

    task automatic wait_idx64(input logic [6:0] target);
        int c;
        c = 0;
        while (!(w_vld64 && w_idx64 == target) && c < 200) begin
            @(posedge clk); #1;
            c++;
        end
        check("wait_idx_timeout", 256'(w_idx64), 256'(target));
    endtask

    // ---------------- test sequence ----------------
    typedef struct {
        int          idx;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        int unsigned seed;
        bit          rand_rdy;
    } case_t;

    logic [31:0] cap32 [64];

    initial begin
        vec_t  tbl   [4];
        case_t cases [3];

        tbl[0].idx = 0;  tbl[0].exp = 32'h61626380;
        tbl[1].idx = 15; tbl[1].exp = 32'h00000018;
        tbl[2].idx = 16; tbl[2].exp = 32'h61626380;
        tbl[3].idx = 17; tbl[3].exp = 32'h000F0000;
        cases[0].seed = 11; cases[0].rand_rdy = 1'b0;
        cases[1].seed = 22; cases[1].rand_rdy = 1'b1;
        cases[2].seed = 33; cases[2].rand_rdy = 1'b1;

        rst = 1'b1;
        flush32 = 1'b0; blk_vld32 = 1'b0; w_rdy32 = 1'b0; blk_data32 = '0;
        flush64 = 1'b0; blk_vld64 = 1'b0; w_rdy64 = 1'b0; blk_data64 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_blk_rdy64", 256'(blk_rdy64), 256'(1));
        check("rst_w_vld64", 256'(w_vld64), 256'(0));
        check("rst_w_last64", 256'(w_last64), 256'(0));
        check("rst_w_idx64", 256'(w_idx64), 256'(0));
        check("rst_blk_rdy32", 256'(blk_rdy32), 256'(1));
        check("rst_w_vld32", 256'(w_vld32), 256'(0));
        rst = 1'b0;

        // SHA-256 "abc" block, single lane, no backpressure.
        for (int i = 0; i < 16; i++) mblk[i] = '0;
        mblk[0]  = 64'h61626380;
        mblk[15] = 64'h00000018;
        build_model(1'b0);
        for (int i = 0; i < 16; i++) blk_data32[i*32 +: 32] = mblk[i][31:0];
        blk_vld32 = 1'b1;
        w_rdy32   = 1'b1;
        @(posedge clk); #1;
        blk_vld32 = 1'b0;
        for (int i = 0; i < 64; i++) begin
            check($sformatf("w32_vld@%0d", i), 256'(w_vld32), 256'(1));
            check($sformatf("w32_idx@%0d", i), 256'(w_idx32), 256'(i));
            check($sformatf("w32_data@%0d", i), 256'(w_data32), 256'(mw[i][31:0]));
            check($sformatf("w32_last@%0d", i), 256'(w_last32), 256'(i == 63));
            cap32[i] = w_data32;
            @(posedge clk); #1;
        end
        check("w32_idle_blk_rdy", 256'(blk_rdy32), 256'(1));
        check("w32_idle_w_vld", 256'(w_vld32), 256'(0));
        for (int v = 0; v < 4; v++) begin
            check($sformatf("abc_W%0d", tbl[v].idx), 256'(cap32[tbl[v].idx]), 256'(tbl[v].exp));
        end

        // SHA-512, four lanes: full rate, then random backpressure.
        for (int n = 0; n < 3; n++) begin
            w_rdy64 = 1'b1;
            send_block64(cases[n].seed, 1'b0);
            run_until_empty(cases[n].rand_rdy, 400);
            check($sformatf("case%0d_blk_rdy_after", n), 256'(blk_rdy64), 256'(1));
            check($sformatf("case%0d_w_vld_after", n), 256'(w_vld64), 256'(0));
        end

        // Back-to-back: second block offered continuously while the first streams.
        w_rdy64 = 1'b1;
        send_block64(44, 1'b1);
        send_block_b: begin
            for (int i = 0; i < 16; i++) mblk[i] = {$urandom(), $urandom()};
            build_model(1'b1);
            for (int i = 0; i < 16; i++) blk_data64[i*64 +: 64] = mblk[i];
            push_block64();
        end
        for (int c = 0; c < 100; c++) begin
            if (w_vld64 && w_last64) break;
            @(posedge clk); #1;
        end
        check("b2b_reach_last", 256'(w_last64), 256'(1));
        @(posedge clk); #1;
        check("b2b_gap_w_vld", 256'(w_vld64), 256'(0));
        check("b2b_gap_blk_rdy", 256'(blk_rdy64), 256'(1));
        @(posedge clk); #1;
        blk_vld64 = 1'b0;
        check("b2b_first_vld", 256'(w_vld64), 256'(1));
        check("b2b_first_idx", 256'(w_idx64), 256'(0));
        run_until_empty(1'b0, 200);

        // Flush at idx 20 with a block offered in the same cycle.
        send_block64(55, 1'b0);
        wait_idx64(7'd20);
        flush64 = 1'b1;
        for (int i = 0; i < 16; i++) mblk[i] = {$urandom(), $urandom()};
        build_model(1'b1);
        for (int i = 0; i < 16; i++) blk_data64[i*64 +: 64] = mblk[i];
        blk_vld64 = 1'b1;
        @(posedge clk); #1;
        flush64 = 1'b0;
        sbq.delete();
        check("flush_w_vld", 256'(w_vld64), 256'(0));
        check("flush_blk_rdy", 256'(blk_rdy64), 256'(1));
        check("flush_w_idx", 256'(w_idx64), 256'(0));
        push_block64();
        @(posedge clk); #1;
        blk_vld64 = 1'b0;
        check("post_flush_vld", 256'(w_vld64), 256'(1));
        check("post_flush_idx", 256'(w_idx64), 256'(0));
        run_until_empty(1'b1, 400);

        // Reset in the middle of a block.
        send_block64(66, 1'b0);
        wait_idx64(7'd32);
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_blk_rdy", 256'(blk_rdy64), 256'(1));
        check("midrst_w_vld", 256'(w_vld64), 256'(0));
        check("midrst_w_idx", 256'(w_idx64), 256'(0));
        check("midrst_w_last", 256'(w_last64), 256'(0));
        rst = 1'b0;
        sbq.delete();
        send_block64(77, 1'b0);
        run_until_empty(1'b0, 200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
